// File: rtl/ciu_dispatcher_if.sv
// Core <-> dispatcher <-> custom-instruction-unit signal bundle.
// The dispatcher takes the slave side; the core/CIU environment takes the master side.
interface ciu_dispatcher_if #(
    parameter int CNT_W = 16
) ();
    logic             instr_valid;
    logic             instr_ready;
    logic [19:0]      instr_data;
    logic [3:0]       ciu_opcode;
    logic [18:0]      ciu_r1;
    logic [18:0]      ciu_r2;
    logic [18:0]      ciu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [18:0]      rsp_data;
    logic [3:0]       rsp_opcode;
    logic             rsp_err;
    logic             busy;
    logic [CNT_W-1:0] issue_count;

    modport slave (
        input  instr_valid, instr_data, ciu_result, rsp_ready,
        output instr_ready, ciu_opcode, ciu_r1, ciu_r2,
               rsp_valid, rsp_data, rsp_opcode, rsp_err, busy, issue_count
    );

    modport master (
        output instr_valid, instr_data, ciu_result, rsp_ready,
        input  instr_ready, ciu_opcode, ciu_r1, ciu_r2,
               rsp_valid, rsp_data, rsp_opcode, rsp_err, busy, issue_count
    );
endinterface

// File: rtl/ciu_dispatcher.sv
// Custom-instruction initiator: queues packed instruction words, strobes them to the CIU
// one at a time and returns each captured result in order over a valid/ready channel.
module ciu_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    ciu_dispatcher_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] OP_SPM = 4'd4;

    // state   | meaning
    // IDLE    | waiting for a queued word; pops the head when one is present
    // ISSUE   | opcode/r1/r2 strobed to the CIU for this single cycle
    // CAPTURE | CIU result registered this cycle, latched at the closing edge
    // RESP    | response held on rsp_* until the core accepts it
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t state, state_nxt;

    logic [19:0]      mem [FIFO_DEPTH];
    logic [19:0]      head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, pop, head_legal;

    logic [3:0]       cur_op;
    logic [7:0]       cur_r1, cur_r2;
    logic [18:0]      rsp_data_q;
    logic             rsp_err_q;
    logic [CNT_W-1:0] cnt_q;

    assign head       = mem[rd_ptr];
    assign head_legal = (head[19:16] != 4'd0) && !head[19];
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    // Full refuses the push even if the FSM pops in the same cycle.
    assign push       = bus.instr_valid && !full;
    assign pop        = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.instr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = head_legal ? ISSUE : RESP;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ciu_opcode = 4'd0;
        bus.ciu_r1     = '0;
        bus.ciu_r2     = '0;
        bus.rsp_valid  = 1'b0;
        case (state)
            ISSUE: begin
                bus.ciu_opcode = cur_op;
                bus.ciu_r1     = {11'd0, cur_r1};
                bus.ciu_r2     = {11'd0, cur_r2};
            end
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_op     <= '0;
            cur_r1     <= '0;
            cur_r2     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (pop) begin
                cur_op     <= head[19:16];
                cur_r1     <= head[15:8];
                cur_r2     <= head[7:0];
                rsp_data_q <= '0;
                rsp_err_q  <= !head_legal;
            end
            if (state == ISSUE) cnt_q <= cnt_q + 1'b1;
            // SPM leaves the CIU result register untouched, so its stale value is masked.
            if (state == CAPTURE) rsp_data_q <= (cur_op == OP_SPM) ? '0 : bus.ciu_result;
        end
    end

    assign bus.instr_ready = !full;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_opcode  = cur_op;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = (state != IDLE) || !empty;
    assign bus.issue_count = cnt_q;
endmodule
